// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: geometry, entry layout,
// and PC index/tag extraction.
package btb_pkg;

  localparam int B_SETS = 3;                  // log2 of set count
  localparam int WAYS   = 4;                  // associativity (tree pLRU assumes 4)
  localparam int B_ADDR = 32;                 // PC / target width
  localparam int SETS   = 1 << B_SETS;
  localparam int IDX_W  = B_SETS;
  localparam int TAG_W  = B_ADDR - B_SETS - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [B_ADDR-1:0] target;
  } btb_entry_t;

  // Set index: word-aligned PC bits just above the byte offset.
  function automatic logic [IDX_W-1:0] pc_index(input logic [B_ADDR-1:0] pc);
    return pc[B_SETS+1:2];
  endfunction

  // Tag: every PC bit above the index.
  function automatic logic [TAG_W-1:0] pc_tag(input logic [B_ADDR-1:0] pc);
    return pc[B_ADDR-1:B_SETS+2];
  endfunction

endpackage

// File: rtl/btb_plru.sv
// Per-set 3-bit tree pseudo-LRU. Bit 0 picks the half (0: ways 0/1,
// 1: ways 2/3), bit 1 picks within ways 0/1, bit 2 within ways 2/3.
// Marking a way MRU points the tree bits on its path away from it.
module btb_plru
  import btb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic [IDX_W-1:0] r_index,
  input  logic [1:0]       r_mru,
  input  logic             load,
  input  logic [IDX_W-1:0] w_index,
  input  logic [1:0]       w_mru,
  output logic [1:0]       plru
);

  logic [2:0] plru_q [SETS];
  logic [2:0] plru_d [SETS];

  // Next tree state: lookup hit applied first, update applied on top so its bits win.
  always_comb begin
    for (int i = 0; i < SETS; i++) begin
      plru_d[i] = plru_q[i];
      if (read && (r_index == IDX_W'(i))) begin
        plru_d[i][0] = ~r_mru[1];
        if (r_mru[1]) plru_d[i][2] = ~r_mru[0];
        else          plru_d[i][1] = ~r_mru[0];
      end
      if (load && (w_index == IDX_W'(i))) begin
        plru_d[i][0] = ~w_mru[1];
        if (w_mru[1]) plru_d[i][2] = ~w_mru[0];
        else          plru_d[i][1] = ~w_mru[0];
      end
    end
  end

  // Tree state register with synchronous clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SETS; i++) begin
      if (reset) plru_q[i] <= 3'b000;
      else       plru_q[i] <= plru_d[i];
    end
  end

  // Victim for the update set, following the tree bits.
  always_comb begin
    plru = plru_q[w_index][0] ? {1'b1, plru_q[w_index][2]} : {1'b0, plru_q[w_index][1]};
  end

endmodule

// File: rtl/btb_array.sv
// Four-way set-associative BTB storage. One lookup and one branch update are
// accepted every cycle with no back-pressure; lookup results are registered,
// updates land at the clock edge, and same-cycle lookups see pre-update state.
// Only the package's default geometry (8 sets, 4 ways, 32-bit PC) is supported.
module btb_array
  import btb_pkg::*;
#(
  parameter int b_sets = B_SETS,
  parameter int way    = WAYS,
  parameter int b_addr = B_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_valid,
  input  logic [b_addr-1:0] lk_pc,
  output logic              pred_hit,
  output logic [b_addr-1:0] pred_target,
  output logic [1:0]        pred_way,
  input  logic              upd_valid,
  input  logic [b_addr-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [b_addr-1:0] upd_target,
  input  logic              flush
);

  localparam int NSETS = 1 << b_sets;

  btb_entry_t mem [NSETS][way];

  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic              lk_any, upd_any, any_free;
  logic [1:0]        lk_way, upd_way, free_way, alloc_way, victim;
  logic [b_addr-1:0] lk_tgt;
  logic              plru_load;
  logic [1:0]        wr_way;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  // Lookup: parallel tag compare across the ways of the addressed set.
  always_comb begin
    lk_idx = pc_index(lk_pc);
    lk_tag = pc_tag(lk_pc);
    lk_any = 1'b0;
    lk_way = 2'd0;
    lk_tgt = '0;
    for (int w = 0; w < way; w++) begin
      if (mem[lk_idx][w].valid && (mem[lk_idx][w].tag == lk_tag)) begin
        lk_any = 1'b1;
        lk_way = 2'(w);
        lk_tgt = mem[lk_idx][w].target;
      end
    end
  end

  // Update: find an existing entry, the lowest invalid way, and the final write way.
  always_comb begin
    upd_idx  = pc_index(upd_pc);
    upd_tag  = pc_tag(upd_pc);
    upd_any  = 1'b0;
    upd_way  = 2'd0;
    any_free = 1'b0;
    free_way = 2'd0;
    for (int w = way - 1; w >= 0; w--) begin
      if (!mem[upd_idx][w].valid) begin
        any_free = 1'b1;
        free_way = 2'(w);
      end
    end
    for (int w = 0; w < way; w++) begin
      if (mem[upd_idx][w].valid && (mem[upd_idx][w].tag == upd_tag)) begin
        upd_any = 1'b1;
        upd_way = 2'(w);
      end
    end
    alloc_way = any_free ? free_way : victim;
    wr_way    = upd_any ? upd_way : alloc_way;
    plru_load = upd_valid && upd_taken && !flush;
  end

  btb_plru u_plru (
    .clk     (clk),
    .reset   (~rst),
    .read    (lk_valid && lk_any),
    .r_index (lk_idx),
    .r_mru   (lk_way),
    .load    (plru_load),
    .w_index (upd_idx),
    .w_mru   (wr_way),
    .plru    (victim)
  );

  // Entry storage: flush clears every valid bit and overrides any update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NSETS; s++)
        for (int w = 0; w < way; w++)
          mem[s][w] <= '0;
    end else if (flush) begin
      for (int s = 0; s < NSETS; s++)
        for (int w = 0; w < way; w++)
          mem[s][w].valid <= 1'b0;
    end else if (upd_valid) begin
      if (upd_taken)
        mem[upd_idx][wr_way] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
      else if (upd_any)
        mem[upd_idx][upd_way].valid <= 1'b0;
    end
  end

  // Registered prediction; an idle cycle or a miss reports zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_hit    <= 1'b0;
      pred_target <= '0;
      pred_way    <= 2'd0;
    end else begin
      pred_hit    <= lk_valid && lk_any;
      pred_target <= (lk_valid && lk_any) ? lk_tgt : '0;
      pred_way    <= (lk_valid && lk_any) ? lk_way : 2'd0;
    end
  end

endmodule

// File: tb/tb_btb_array.sv
// Directed bench for btb_array: allocation, pLRU victim choice, overwrite,
// invalidation, same-cycle ordering, flush and asynchronous reset.
module tb_btb_array;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        pred_hit;
  logic [31:0] pred_target;
  logic [1:0]  pred_way;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        flush = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Set-1 aliases (pc[4:2] == 1) with distinct tags, plus PCs in other sets.
  localparam logic [31:0] PC_A = 32'h0000_1004;
  localparam logic [31:0] PC_B = 32'h0000_2004;
  localparam logic [31:0] PC_C = 32'h0000_3004;
  localparam logic [31:0] PC_D = 32'h0000_4004;
  localparam logic [31:0] PC_E = 32'h0000_5004;
  localparam logic [31:0] PC_F = 32'h0000_6008;
  localparam logic [31:0] PC_G = 32'h0000_700C;
  localparam logic [31:0] PC_H = 32'h0000_8010;

  always #5 clk = ~clk;

  btb_array dut (
    .clk         (clk),
    .rst         (rst),
    .lk_valid    (lk_valid),
    .lk_pc       (lk_pc),
    .pred_hit    (pred_hit),
    .pred_target (pred_target),
    .pred_way    (pred_way),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush       (flush)
  );

  // One cycle of stimulus; returns 1 time unit after the edge so outputs can be sampled.
  task automatic cyc(input logic lv, input logic [31:0] lp, input logic uv,
                     input logic [31:0] up, input logic ut, input logic [31:0] utg,
                     input logic fl);
    lk_valid = lv; lk_pc = lp;
    upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
    flush = fl;
    @(posedge clk);
    #1;
    lk_valid = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0; flush = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    cyc(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    cyc(1'b0, '0, 1'b1, pc, taken, tgt, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit: got %b want 0", pred_hit); end
    n_cmp++; if (pred_target !== 32'h0) begin n_bad++; $display("FAIL reset_target: got %h want 0", pred_target); end
    n_cmp++; if (pred_way !== 2'd0) begin n_bad++; $display("FAIL reset_way: got %0d want 0", pred_way); end
    rst = 1'b1;
    lookup(32'h0000_1000);
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL first_lookup_hit: got %b want 0", pred_hit); end
    n_cmp++; if (pred_target !== 32'h0) begin n_bad++; $display("FAIL first_lookup_target: got %h want 0", pred_target); end
  endtask

  task automatic test_alloc_basic();
    update(PC_A, 1'b1, 32'h0000_2000);
    lookup(PC_A);
    n_cmp++; if (pred_hit !== 1'b1) begin n_bad++; $display("FAIL basic_hit: got %b want 1", pred_hit); end
    n_cmp++; if (pred_target !== 32'h0000_2000) begin n_bad++; $display("FAIL basic_target: got %h want 00002000", pred_target); end
    n_cmp++; if (pred_way !== 2'd0) begin n_bad++; $display("FAIL basic_way: got %0d want 0", pred_way); end
  endtask

  task automatic test_plru_victim();
    update(PC_B, 1'b1, 32'h0000_2200);
    update(PC_C, 1'b1, 32'h0000_3300);
    update(PC_D, 1'b1, 32'h0000_4400);
    lookup(PC_B);
    n_cmp++; if (pred_way !== 2'd1 || pred_target !== 32'h0000_2200) begin n_bad++; $display("FAIL fill_b: got way %0d tgt %h want way 1 tgt 00002200", pred_way, pred_target); end
    lookup(PC_D);
    n_cmp++; if (pred_way !== 2'd3 || pred_target !== 32'h0000_4400) begin n_bad++; $display("FAIL fill_d: got way %0d tgt %h want way 3 tgt 00004400", pred_way, pred_target); end
    // Last two hits are ways 0 then 2, leaving way 1 as the pLRU victim.
    lookup(PC_A);
    n_cmp++; if (pred_hit !== 1'b1 || pred_way !== 2'd0) begin n_bad++; $display("FAIL fill_a: got hit %b way %0d want hit 1 way 0", pred_hit, pred_way); end
    lookup(PC_C);
    n_cmp++; if (pred_hit !== 1'b1 || pred_way !== 2'd2 || pred_target !== 32'h0000_3300) begin n_bad++; $display("FAIL fill_c: got hit %b way %0d tgt %h want 1 2 00003300", pred_hit, pred_way, pred_target); end
    update(PC_E, 1'b1, 32'h0000_5500);
    lookup(PC_E);
    n_cmp++; if (pred_hit !== 1'b1 || pred_way !== 2'd1 || pred_target !== 32'h0000_5500) begin n_bad++; $display("FAIL victim_e: got hit %b way %0d tgt %h want 1 1 00005500", pred_hit, pred_way, pred_target); end
    lookup(PC_B);
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL evicted_b: got hit %b want 0", pred_hit); end
  endtask

  task automatic test_overwrite_invalidate();
    update(PC_A, 1'b1, 32'h0000_3000);
    lookup(PC_A);
    n_cmp++; if (pred_hit !== 1'b1 || pred_way !== 2'd0 || pred_target !== 32'h0000_3000) begin n_bad++; $display("FAIL overwrite_a: got hit %b way %0d tgt %h want 1 0 00003000", pred_hit, pred_way, pred_target); end
    lookup(PC_C);
    n_cmp++; if (pred_hit !== 1'b1 || pred_way !== 2'd2) begin n_bad++; $display("FAIL no_alloc_c: got hit %b way %0d want 1 2", pred_hit, pred_way); end
    // Not-taken for an absent PC leaves the set untouched.
    update(PC_B, 1'b0, 32'h0000_dead);
    lookup(PC_D);
    n_cmp++; if (pred_hit !== 1'b1 || pred_way !== 2'd3 || pred_target !== 32'h0000_4400) begin n_bad++; $display("FAIL nt_absent_d: got hit %b way %0d tgt %h want 1 3 00004400", pred_hit, pred_way, pred_target); end
    update(PC_A, 1'b0, 32'h0);
    lookup(PC_A);
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL invalidate_hit: got %b want 0", pred_hit); end
    n_cmp++; if (pred_target !== 32'h0 || pred_way !== 2'd0) begin n_bad++; $display("FAIL invalidate_zero: got tgt %h way %0d want 0 0", pred_target, pred_way); end
  endtask

  task automatic test_same_cycle();
    cyc(1'b1, PC_F, 1'b1, PC_F, 1'b1, 32'h0000_6600, 1'b0);
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL same_cycle_hit: got %b want 0", pred_hit); end
    lookup(PC_F);
    n_cmp++; if (pred_hit !== 1'b1 || pred_way !== 2'd0 || pred_target !== 32'h0000_6600) begin n_bad++; $display("FAIL next_cycle_f: got hit %b way %0d tgt %h want 1 0 00006600", pred_hit, pred_way, pred_target); end
  endtask

  task automatic test_back_to_back();
    // Consecutive lookups alternate between sets every cycle.
    lookup(PC_E);
    n_cmp++; if (pred_target !== 32'h0000_5500) begin n_bad++; $display("FAIL b2b_e: got %h want 00005500", pred_target); end
    lookup(PC_F);
    n_cmp++; if (pred_target !== 32'h0000_6600) begin n_bad++; $display("FAIL b2b_f: got %h want 00006600", pred_target); end
    cyc(1'b0, PC_E, 1'b0, '0, 1'b0, '0, 1'b0);
    n_cmp++; if (pred_hit !== 1'b0 || pred_target !== 32'h0) begin n_bad++; $display("FAIL b2b_idle: got hit %b tgt %h want 0 0", pred_hit, pred_target); end
  endtask

  task automatic test_flush();
    // Same-cycle lookup still sees pre-flush contents.
    cyc(1'b1, PC_E, 1'b1, PC_G, 1'b1, 32'h0000_7700, 1'b1);
    n_cmp++; if (pred_hit !== 1'b1 || pred_way !== 2'd1 || pred_target !== 32'h0000_5500) begin n_bad++; $display("FAIL flush_pre: got hit %b way %0d tgt %h want 1 1 00005500", pred_hit, pred_way, pred_target); end
    lookup(PC_G);
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL flush_g: got %b want 0", pred_hit); end
    lookup(PC_E);
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL flush_e: got %b want 0", pred_hit); end
    lookup(PC_F);
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL flush_f: got %b want 0", pred_hit); end
    lookup(PC_C);
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL flush_c: got %b want 0", pred_hit); end
  endtask

  task automatic test_async_reset();
    update(PC_H, 1'b1, 32'h0000_8800);
    lookup(PC_H);
    n_cmp++; if (pred_hit !== 1'b1 || pred_target !== 32'h0000_8800) begin n_bad++; $display("FAIL pre_reset_h: got hit %b tgt %h want 1 00008800", pred_hit, pred_target); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (pred_hit !== 1'b0 || pred_target !== 32'h0) begin n_bad++; $display("FAIL async_reset: got hit %b tgt %h want 0 0", pred_hit, pred_target); end
    @(posedge clk);
    #1 rst = 1'b1;
    lookup(PC_H);
    n_cmp++; if (pred_hit !== 1'b0) begin n_bad++; $display("FAIL post_reset_h: got %b want 0", pred_hit); end
  endtask

  initial begin
    test_reset();
    test_alloc_basic();
    test_plru_victim();
    test_overwrite_invalidate();
    test_same_cycle();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
